pipe_ex_mdu: RTL and testbench
==============================

Name: pipe_ex_mdu

Overview:
- Shared iterative RV64M multiply/divide unit beside the N-lane execute stage.
- Accepts one M-extension op per transaction from any of ISSUE_NUM lanes; lowest-indexed valid lane wins.
- Holds the execute pipe via stall while iterating, then returns one registered result tagged with lane and rd.
- Supports full-width and W (32-bit word) forms.

Parameters:
- XLEN, 64, datapath width; power of two, at least 32.
- ISSUE_NUM, 2, number of requesting lanes.
- LANE_W, $clog2(ISSUE_NUM) (minimum 1), width of the lane tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; kills any in-flight op.
- req_valid  in  ISSUE_NUM  per-lane M-op request.
- req_op  in  ISSUE_NUM*3  per-lane funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_word32  in  ISSUE_NUM  per-lane W-form flag.
- req_a  in  ISSUE_NUM*XLEN  per-lane rs1 value.
- req_b  in  ISSUE_NUM*XLEN  per-lane rs2 value.
- req_rd  in  ISSUE_NUM*5  per-lane destination register.
- req_grant  out  ISSUE_NUM  one-hot; the lane accepted this cycle.
- stall  out  1  hold the execute pipe.
- resp_valid  out  1  one-cycle result pulse.
- resp_lane  out  LANE_W  lane index of the result.
- resp_rd  out  5  destination register of the result.
- resp_data  out  XLEN  result value.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, counter=0, resp_valid=0, resp_lane=0, resp_rd=0, resp_data=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If any req_valid and !flush: grant the lowest-index valid lane (req_grant combinational, that lane only).
  - Latch the granted lane's op, word32, a, b, rd and lane index.
  - Next state: MUL for op<4. DIV for op>=4, except special cases go straight to DONE.
- Operand preparation:
  - word32=1: low 32 bits of each operand, sign-extended for MUL/DIV/REM, zero-extended for DIVU/REMU.
  - Signed ops: magnitudes taken at accept; result sign fixed on the final iteration.
  - MULHSU: a signed, b unsigned.
- MUL/DIV: radix-2 shift-add / restoring shift-subtract, one bit per cycle.
  - Iterations: XLEN, or 32 when word32=1. Counter counts down to 0; at 0 the result is written to resp_data and the next state is DONE.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits of the product.
  - DIV*: quotient. REM*: remainder.
  - word32=1: result is the low 32 bits sign-extended to XLEN.
  - word32=1 with MULH*: treated as MULW; the decoder never emits it.
- Special cases (accept → DONE, 1 cycle):
  - Divide by zero: quotient = all ones; remainder = dividend (after W extension).
  - Signed overflow (most negative / -1): quotient = dividend; remainder = 0.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. No new request is accepted in DONE.
- Latency, with accept in cycle 0:
  - Iterative ops: resp_valid in cycle N+1 (N = 64 or 32).
  - Special cases: resp_valid in cycle 1.
  - Back-to-back ops: the next accept is at the earliest in the cycle after DONE.
- stall:
  - High in MUL, DIV and DONE.
  - High in IDLE when any req_valid is present (the accept cycle).
  - Low in IDLE with no request.
- Multiple valid lanes: only the lowest is granted. Higher lanes keep their requests asserted (the pipe is stalled) and are granted in later transactions, in lane order.
- Flush:
  - In any state: next state IDLE, counter cleared, resp_valid=0 next cycle.
  - Flush coincident with the DONE cycle: that cycle's resp_valid still fires, because it is registered from the prior cycle.
  - Flush in IDLE: blocks acceptance; req_grant=0.
- resp_lane, resp_rd, resp_data hold their last values outside DONE.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MUL-class ops compute the full 2*XLEN product in one cycle.
  - State goes accept → DONE, so resp_valid arrives in cycle 1.
  - The MUL state is unused; DIV timing is unchanged.
- Undefined: iterative multiply as described above; no wide multiplier is inferred.

Test Plan:
- Lane 0: MUL a=7, b=-3 (64-bit) → resp_valid in cycle 65, resp_data=0xFFFFFFFFFFFFFFEB, resp_lane=0. With MDU_FAST_MUL_EN: resp_valid in cycle 1.
- Lane 1 only: DIVW a=0x00000000FFFFFFF9 (-7 as word), b=2 → cycle 33, resp_data=0xFFFFFFFFFFFFFFFD (-3), resp_lane=1. REMW on the same operands → 0xFFFFFFFFFFFFFFFF.
- DIVU a=5, b=0 → cycle 1, resp_data=all ones. REMU on the same operands → resp_data=5.
- DIV a=0x8000000000000000, b=-1 → cycle 1, resp_data=0x8000000000000000. REM → 0.
- Both lanes valid:
  - Lane 0 MULHU a=b=0xFFFFFFFFFFFFFFFF → first result 0xFFFFFFFFFFFFFFFE, lane 0.
  - Lane 1 DIVU 100/7, held asserted → granted the cycle after DONE, result 14, lane 1.
  - stall high throughout.
- Flush in cycle 10 of a DIV → state IDLE in cycle 11, no resp_valid. A new request in cycle 11 is accepted normally.
- rst asserted mid-MUL → outputs and state return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ex_mdu.sv
// pipe_ex_mdu: shared iterative RV64M multiply/divide unit beside the execute stage.
//
// One M-extension op is accepted at a time from any of ISSUE_NUM lanes (lowest
// valid lane wins). The execute pipe is held via stall while the unit iterates
// one bit per cycle (shift-add multiply, restoring divide). A single registered
// result pulse tagged with lane and rd is returned.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   flush          kills any in-flight op, blocks acceptance in IDLE
//   req_valid      per-lane request
//   req_op         per-lane funct3 (3 bits/lane)
//   req_word32     per-lane W-form flag
//   req_a, req_b   per-lane rs1/rs2 (XLEN bits/lane)
//   req_rd         per-lane destination register (5 bits/lane)
//   req_grant      one-hot accepted lane (combinational)
//   stall          hold the execute pipe
//   resp_valid     one-cycle result pulse
//   resp_lane, resp_rd, resp_data   result tag and value (held outside DONE)
//
// Build option: define MDU_FAST_MUL_EN to compute MUL-class ops with a single
// wide multiplier (accept -> DONE); otherwise multiply iterates like divide.

module pipe_ex_mdu #(
    parameter int XLEN      = 64,
    parameter int ISSUE_NUM = 2,
    parameter int LANE_W    = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [ISSUE_NUM-1:0]      req_valid,
    input  logic [ISSUE_NUM*3-1:0]    req_op,
    input  logic [ISSUE_NUM-1:0]      req_word32,
    input  logic [ISSUE_NUM*XLEN-1:0] req_a,
    input  logic [ISSUE_NUM*XLEN-1:0] req_b,
    input  logic [ISSUE_NUM*5-1:0]    req_rd,
    output logic [ISSUE_NUM-1:0]      req_grant,
    output logic                      stall,
    output logic                      resp_valid,
    output logic [LANE_W-1:0]         resp_lane,
    output logic [4:0]                resp_rd,
    output logic [XLEN-1:0]           resp_data
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Apply the result sign, pick low/high product half, then W-form extension.
    function automatic logic [XLEN-1:0] fin_mul(input logic [2*XLEN-1:0] p, input logic neg,
                                                input logic [2:0] op, input logic w);
        logic [2*XLEN-1:0] ps;
        logic [XLEN-1:0]   r;
        ps = neg ? -p : p;
        r  = (op == 3'd0 || w) ? ps[XLEN-1:0] : ps[2*XLEN-1:XLEN];
        return w ? sext32(r[31:0]) : r;
    endfunction

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            w_q, negq_q, negr_q;
    logic [LANE_W-1:0] lane_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] mcand;      // multiplicand (MUL) or divisor magnitude (DIV)
    logic [XLEN-1:0] hi, lo;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}

    // ---------------- lane selection ----------------
    int               sel_idx;
    logic             sel_found;
    logic [LANE_W-1:0] sel_lane;
    logic [2:0]       sel_op;
    logic             sel_w;
    logic [XLEN-1:0]  sel_a, sel_b;
    logic [4:0]       sel_rd;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 0;
        sel_lane  = '0;
        // Descending scan so the lowest valid lane is the last one written.
        for (int i = ISSUE_NUM-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                sel_found = 1'b1;
                sel_idx   = i;
                sel_lane  = LANE_W'(i);
            end
        end
        sel_op = req_op[sel_idx*3 +: 3];
        sel_w  = req_word32[sel_idx];
        sel_a  = req_a[sel_idx*XLEN +: XLEN];
        sel_b  = req_b[sel_idx*XLEN +: XLEN];
        sel_rd = req_rd[sel_idx*5 +: 5];
    end

    logic accept;
    assign accept = (state == S_IDLE) && !flush && sel_found;
    assign stall  = (state != S_IDLE) || (|req_valid);

    always_comb begin
        req_grant = '0;
        if (accept) req_grant[sel_idx] = 1'b1;
    end

    // ---------------- operand preparation ----------------
    logic            w_uns, a_sgn, b_sgn, sa, sb, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_x, b_x, a_mag, b_mag, min_val, spec_res;

    always_comb begin
        w_uns    = (sel_op == 3'd5) || (sel_op == 3'd7);
        a_x      = sel_w ? (w_uns ? {{(XLEN-32){1'b0}}, sel_a[31:0]} : sext32(sel_a[31:0])) : sel_a;
        b_x      = sel_w ? (w_uns ? {{(XLEN-32){1'b0}}, sel_b[31:0]} : sext32(sel_b[31:0])) : sel_b;
        // MUL is handled unsigned: the low product bits do not depend on signedness.
        a_sgn    = (sel_op == 3'd1) || (sel_op == 3'd2) || (sel_op == 3'd4) || (sel_op == 3'd6);
        b_sgn    = (sel_op == 3'd1) || (sel_op == 3'd4) || (sel_op == 3'd6);
        sa       = a_sgn & a_x[XLEN-1];
        sb       = b_sgn & b_x[XLEN-1];
        a_mag    = sa ? -a_x : a_x;
        b_mag    = sb ? -b_x : b_x;
        is_div   = sel_op[2];
        min_val  = sel_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_x == '0);
        div_ovf  = is_div && !sel_op[0] && (a_x == min_val) && (&b_x);
        // op[1] distinguishes REM* from DIV*.
        if (div_zero) spec_res = sel_op[1] ? a_x : '1;
        else          spec_res = sel_op[1] ? '0 : a_x;
        if (sel_w) spec_res = sext32(spec_res[31:0]);
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        fast_res  = fin_mul(fast_prod, sa ^ sb, sel_op, sel_w);
    end
`endif

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum, div_r;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n, div_diff, div_hi_n, div_lo_n;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_al;
    logic [XLEN-1:0]   mul_res, quo, rem, div_res;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};

        div_r    = {hi, lo[XLEN-1]};
        div_ge   = div_r >= {1'b0, mcand};
        div_diff = div_r[XLEN-1:0] - mcand;
        div_hi_n = div_ge ? div_diff : div_r[XLEN-1:0];
        div_lo_n = {lo[XLEN-2:0], div_ge};

        // A 32-iteration word multiply leaves the product XLEN-32 bits up.
        prod_al  = w_q ? ({mul_hi_n, mul_lo_n} >> (XLEN-32)) : {mul_hi_n, mul_lo_n};
        mul_res  = fin_mul(prod_al, negq_q, op_q, w_q);

        quo      = negq_q ? -div_lo_n : div_lo_n;
        rem      = negr_q ? -div_hi_n : div_hi_n;
        div_res  = op_q[1] ? rem : quo;
        if (w_q) div_res = sext32(div_res[31:0]);
    end

    // ---------------- control / datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_lane  <= '0;
            resp_rd    <= '0;
            resp_data  <= '0;
            op_q       <= '0;
            w_q        <= 1'b0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            lane_q     <= '0;
            rd_q       <= '0;
            mcand      <= '0;
            hi         <= '0;
            lo         <= '0;
        end else if (flush) begin
            state      <= S_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    resp_valid <= 1'b0;
                    if (accept) begin
                        op_q   <= sel_op;
                        w_q    <= sel_w;
                        negq_q <= sa ^ sb;
                        negr_q <= sa;
                        lane_q <= sel_lane;
                        rd_q   <= sel_rd;
                        cnt    <= sel_w ? CW'(31) : CW'(XLEN-1);
                        if (div_zero || div_ovf) begin
                            resp_data  <= spec_res;
                            resp_lane  <= sel_lane;
                            resp_rd    <= sel_rd;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end else if (is_div) begin
                            mcand <= b_mag;
                            hi    <= '0;
                            // Word dividends sit in the top 32 bits so 32 steps consume them.
                            lo    <= sel_w ? (a_mag << (XLEN-32)) : a_mag;
                            state <= S_DIV;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            resp_data  <= fast_res;
                            resp_lane  <= sel_lane;
                            resp_rd    <= sel_rd;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
`else
                            mcand <= a_mag;
                            hi    <= '0;
                            lo    <= b_mag;
                            state <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    hi <= mul_hi_n;
                    lo <= mul_lo_n;
                    if (cnt == '0) begin
                        resp_data  <= mul_res;
                        resp_lane  <= lane_q;
                        resp_rd    <= rd_q;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    hi <= div_hi_n;
                    lo <= div_lo_n;
                    if (cnt == '0) begin
                        resp_data  <= div_res;
                        resp_lane  <= lane_q;
                        resp_rd    <= rd_q;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin  // S_DONE
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ex_mdu.sv
// Scoreboard bench for pipe_ex_mdu: stimulus pushes model results, a monitor
// pops and compares on every resp_valid pulse (data, tag and arrival cycle).
module tb_pipe_ex_mdu;
    localparam int XLEN = 64;
    localparam int NL   = 2;
    localparam int LW   = 1;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic [NL-1:0]     req_valid, req_word32, req_grant;
    logic [NL*3-1:0]   req_op;
    logic [NL*XLEN-1:0] req_a, req_b;
    logic [NL*5-1:0]   req_rd;
    logic              stall, resp_valid;
    logic [LW-1:0]     resp_lane;
    logic [4:0]        resp_rd;
    logic [XLEN-1:0]   resp_data;

    pipe_ex_mdu #(.XLEN(XLEN), .ISSUE_NUM(NL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_word32(req_word32),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .req_grant(req_grant), .stall(stall),
        .resp_valid(resp_valid), .resp_lane(resp_lane), .resp_rd(resp_rd), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [LW-1:0] lane;
        logic [4:0]    rd;
        logic [63:0]   data;
        int            due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   stall_chk = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    // Reference: RV64M semantics computed with plain wide arithmetic.
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input bit w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [31:0]  ua, ub, r32;
        int           sa32, sb32;
        longint       sa, sb;
        if (w) begin
            ua = a[31:0]; ub = b[31:0];
            sa32 = $signed(ua); sb32 = $signed(ub);
            case (op)
                3'd4: r32 = (ub == 0) ? 32'hFFFF_FFFF :
                            (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) ? ua : 32'(sa32 / sb32);
                3'd5: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
                3'd6: r32 = (ub == 0) ? ua :
                            (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa32 % sb32);
                3'd7: r32 = (ub == 0) ? ua : ua % ub;
                default: r32 = ua * ub;
            endcase
            return {{32{r32[31]}}, r32};
        end
        sa = $signed(a); sb = $signed(b);
        case (op)
            3'd0: return a * b;
            3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
            3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'b0, b};      p = pa * pb; return p[127:64]; end
            3'd3: begin pa = {64'b0, a};       pb = {64'b0, b};      p = pa * pb; return p[127:64]; end
            3'd4: return (b == 0) ? '1 : (a == MIN64 && b == '1) ? a : 64'(sa / sb);
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: return (b == 0) ? a  : (a == MIN64 && b == '1) ? 64'h0 : 64'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input bit w,
                                   input logic [63:0] a, input logic [63:0] b);
        bit bz, ovf;
        bz  = w ? (b[31:0] == 0) : (b == 0);
        ovf = (op == 3'd4 || op == 3'd6) &&
              (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == '1));
        if (op >= 3'd4 && (bz || ovf)) return 1;
`ifdef MDU_FAST_MUL_EN
        if (op < 3'd4) return 1;
`endif
        return w ? 33 : 65;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present a request on one lane until granted; optionally queue its expected result.
    task automatic issue(input int lane, input logic [2:0] op, input bit w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input bit push, output int acc);
        logic [NL-1:0] onehot;
        exp_t e;
        req_op[lane*3 +: 3]       = op;
        req_word32[lane]          = w;
        req_a[lane*XLEN +: XLEN]  = a;
        req_b[lane*XLEN +: XLEN]  = b;
        req_rd[lane*5 +: 5]       = rd;
        req_valid[lane]           = 1'b1;
        acc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (req_grant[lane]) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL grant_timeout lane %0d: got no grant, required one", lane);
        end else begin
            onehot = '0; onehot[lane] = 1'b1;
            chk("grant_onehot", 64'(req_grant), 64'(onehot));
            if (push) begin
                e.lane = LW'(lane); e.rd = rd; e.data = ref_mdu(op, w, a, b);
                e.due  = acc + ref_lat(op, w, a, b);
                sbq.push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid[lane] = 1'b0;
    endtask

    // Monitor: compare every result pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_chk) begin
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: got %b expected 1", cyc, stall);
                end
            end
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp cycle %0d: got resp_valid=1 expected 0 (data %h)", cyc, resp_data);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("resp_data", resp_data, mon_e.data);
                    chk("resp_tag", {57'b0, resp_lane, resp_rd}, {57'b0, mon_e.lane, mon_e.rd});
                    chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
        end
    end

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'h0;
            1: return '1;
            2: return MIN64;
            3: return 64'($urandom_range(0, 20));
            4: return {$urandom(), 32'h8000_0000};
            5: return {32'hFFFF_FFFF, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s: got %0d pending results, expected 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, acc2;
        logic [2:0]  op;
        logic [63:0] a, b;
        bit          w;
        int          lane;

        rst = 1'b0; flush = 1'b0;
        req_valid = '0; req_word32 = '0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
        #2 rst = 1'b1;
        #10;
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_lane",  64'(resp_lane),  64'h0);
        chk("rst_resp_rd",    64'(resp_rd),    64'h0);
        chk("rst_resp_data",  resp_data,       64'h0);
        chk("rst_stall",      64'(stall),      64'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        issue(0, 3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1, acc0);
        issue(1, 3'd4, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd6, 1, acc0);
        issue(1, 3'd6, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd7, 1, acc0);
        issue(0, 3'd5, 0, 64'd5, 64'd0, 5'd8, 1, acc0);
        issue(0, 3'd7, 0, 64'd5, 64'd0, 5'd9, 1, acc0);
        issue(0, 3'd4, 0, MIN64, '1, 5'd10, 1, acc0);
        issue(0, 3'd6, 0, MIN64, '1, 5'd11, 1, acc0);
        drain("drain_directed");

        // Both lanes requesting: lane 0 first, lane 1 the cycle after DONE.
        @(posedge clk); #1;
        stall_chk = 1'b1;
        fork
            issue(0, 3'd3, 0, '1, '1, 5'd12, 1, acc0);
            issue(1, 3'd5, 0, 64'd100, 64'd7, 5'd13, 1, acc1);
        join
        chk("lane1_accept_cycle", 64'(acc1), 64'(acc0 + ref_lat(3'd3, 0, '1, '1) + 1));
        while (sbq.size() != 0 && (cyc - acc1) < 300) @(posedge clk);
        stall_chk = 1'b0;
        drain("drain_both");

        // Flush in cycle 10 of a DIV; a request in cycle 11 is accepted.
        @(posedge clk); #1;
        issue(0, 3'd4, 0, 64'd12345, 64'd3, 5'd14, 0, acc0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        issue(1, 3'd5, 0, 64'd1000, 64'd10, 5'd15, 1, acc2);
        chk("post_flush_accept", 64'(acc2), 64'(acc0 + 11));
        drain("drain_flush");

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        issue(0, 3'd0, 0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'd16, 0, acc0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'h0);
        chk("midrst_resp_lane",  64'(resp_lane),  64'h0);
        chk("midrst_resp_rd",    64'(resp_rd),    64'h0);
        chk("midrst_resp_data",  resp_data,       64'h0);
        chk("midrst_stall",      64'(stall),      64'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Randomized single-lane traffic.
        for (int i = 0; i < 30; i++) begin
            op   = 3'($urandom_range(0, 7));
            w    = (op == 3'd0 || op >= 3'd4) ? bit'($urandom_range(0, 1)) : 1'b0;
            a    = pick();
            b    = pick();
            lane = $urandom_range(0, NL-1);
            issue(lane, op, w, a, b, 5'($urandom_range(0, 31)), 1, acc0);
        end
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
